// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package if_pkg;

    // Fetch sequencing: issue a request, wait for its data, or hold data decode refused.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] IF_RESET_PC = 32'hbfc00000;
    localparam logic [31:0] IF_NOP_INST = 32'h00000000;

    // One fetched instruction as handed to decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_pkt_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register that parks a returned instruction while decode stalls.
module if_hold_buf
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  fetch_pkt_t load_pkt,
    input  logic       drain,
    input  logic       clear,
    output logic       valid,
    output fetch_pkt_t pkt
);

    // Occupancy flag: set on load, dropped on drain, clear or reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Payload capture.
    // NOTE: payload is left unreset; valid alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (load) begin
            pkt <= load_pkt;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: issues pc_i on the instruction bus (one outstanding
// transaction), delivers {pc, inst} to decode and pulses pc_en_o once per delivery.
// Optional build macro ADDR_CHECK_EN: misaligned PCs are not issued on the bus and are
// delivered as NOP with if_adel_o set; without it if_adel_o stays 0.
module inst_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        pc_en_o,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_adel_o
);

    fetch_state_e state, state_n;
    logic         discard, discard_n;
    logic [31:0]  pc_q;
    logic         pc_q_load;
    logic         deliver;
    logic         misaligned;
    logic         buf_load, buf_drain, buf_clear, buf_valid;
    fetch_pkt_t   dlv_pkt, buf_pkt, wait_pkt, out_q;
    logic         out_valid;

    assign inst_addr = pc_i;
    assign wait_pkt  = '{pc: pc_q, inst: inst_rdata, adel: 1'b0};

`ifdef ADDR_CHECK_EN
    assign misaligned = (pc_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Next-state, bus request and delivery decisions; flush outranks everything but reset.
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    always_comb begin
        state_n   = state;
        discard_n = discard;
        deliver   = 1'b0;
        dlv_pkt   = wait_pkt;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        buf_clear = 1'b0;
        pc_q_load = 1'b0;
        inst_req  = 1'b0;
        case (state)
            REQ: begin
                if (!flush_i) begin
                    if (misaligned) begin
                        dlv_pkt = '{pc: pc_i, inst: NOP_INST, adel: 1'b1};
                        deliver = !stall_i;
                    end else begin
                        inst_req = 1'b1;
                        if (inst_addr_ok) begin
                            pc_q_load = 1'b1;
                            state_n   = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (flush_i || discard) begin
                        discard_n = 1'b0;
                        state_n   = REQ;
                    end else if (!stall_i) begin
                        deliver = 1'b1;
                        state_n = REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_n  = HOLD;
                    end
                end else if (flush_i) begin
                    discard_n = 1'b1;
                end
            end
            HOLD: begin
                if (flush_i || !buf_valid) begin
                    buf_clear = 1'b1;
                    state_n   = REQ;
                end else if (!stall_i) begin
                    dlv_pkt   = buf_pkt;
                    deliver   = 1'b1;
                    buf_drain = 1'b1;
                    state_n   = REQ;
                end
            end
            default: state_n = REQ;
        endcase
        if (rst) begin
            inst_req = 1'b0;
            deliver  = 1'b0;
        end
    end

    assign pc_en_o = deliver & ~flush_i;

    // Fetch state and pending-response discard flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= REQ;
            discard <= 1'b0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
        end
    end

    // PC of the accepted bus request, paired with its data when it returns.
    always_ff @(posedge clk) begin
        if (pc_q_load) begin
            pc_q <= pc_i;
        end
    end

    // Output register to decode: holds under stall, drops valid when nothing is delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '{pc: RESET_PC, inst: NOP_INST, adel: 1'b0};
        end else if (flush_i) begin
            out_valid  <= 1'b0;
            out_q.adel <= 1'b0;
        end else if (!stall_i) begin
            if (deliver) begin
                out_valid <= 1'b1;
                out_q     <= dlv_pkt;
            end else begin
                out_valid  <= 1'b0;
                out_q.adel <= 1'b0;
            end
        end
    end

    if_hold_buf u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .load_pkt (wait_pkt),
        .drain    (buf_drain),
        .clear    (buf_clear),
        .valid    (buf_valid),
        .pkt      (buf_pkt)
    );

    assign if_valid_o = out_valid;
    assign if_pc_o    = out_q.pc;
    assign if_inst_o  = out_q.inst;
    assign if_adel_o  = out_q.adel;

`ifndef SYNTHESIS
    // A response may only arrive while a request is outstanding.
    data_ok_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        inst_data_ok |-> (state == WAIT));
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, hand-written corner
// sequences, then randomized bus/stall/flush traffic against a transaction-level model.
module tb_inst_fetch;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush_i, stall_i;
    logic        pc_en_o, inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid_o, if_adel_o;
    logic [31:0] if_pc_o, if_inst_o;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .pc_en_o      (pc_en_o),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .if_adel_o    (if_adel_o)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One cycle of directed stimulus and the outputs expected in that cycle.
    typedef struct {
        logic [31:0] pc;
        logic        fl, st, aok, dok;
        logic [31:0] rd;
        logic        e_req, e_pcen, e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pc, input logic fl, input logic st,
                                input logic aok, input logic dok, input logic [31:0] rd,
                                input logic e_req, input logic e_pcen, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.pc = pc; v.fl = fl; v.st = st; v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_req = e_req; v.e_pcen = e_pcen; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    // Instruction memory contents seen by the random bus.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h3c1d0000;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic        drop;
    } txn_t;

    task automatic drive(input logic [31:0] pc, input logic fl, input logic st,
                         input logic aok, input logic dok, input logic [31:0] rd);
        pc_i = pc; flush_i = fl; stall_i = st;
        inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    endtask

    vec_t vecs[26];

    initial begin
        txn_t        outq[$];
        fetch_pkt_t  rdyq[$];
        logic [31:0] pc_reg, tgt, exp_pc, exp_inst;
        logic        exp_valid;

        vecs[0]  = mk(32'hbfc00000, 0, 0, 1, 0, 32'h0,        1, 0, 0, 32'hbfc00000, 32'h0);
        vecs[1]  = mk(32'hbfc00000, 0, 0, 0, 1, 32'h24080001, 0, 1, 0, 32'hbfc00000, 32'h0);
        vecs[2]  = mk(32'hbfc00004, 0, 0, 0, 0, 32'h0,        1, 0, 1, 32'hbfc00000, 32'h24080001);
        vecs[3]  = mk(32'hbfc00004, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'hbfc00000, 32'h24080001);
        vecs[4]  = mk(32'hbfc00004, 0, 0, 1, 0, 32'h0,        1, 0, 0, 32'hbfc00000, 32'h24080001);
        vecs[5]  = mk(32'hbfc00004, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hbfc00000, 32'h24080001);
        vecs[6]  = mk(32'hbfc00004, 0, 0, 0, 1, 32'h8c020010, 0, 1, 0, 32'hbfc00000, 32'h24080001);
        vecs[7]  = mk(32'hbfc00008, 0, 1, 1, 0, 32'h0,        1, 0, 1, 32'hbfc00004, 32'h8c020010);
        vecs[8]  = mk(32'hbfc00008, 0, 1, 0, 1, 32'h3c1d8000, 0, 0, 1, 32'hbfc00004, 32'h8c020010);
        vecs[9]  = mk(32'hbfc00008, 0, 1, 0, 0, 32'h0,        0, 0, 1, 32'hbfc00004, 32'h8c020010);
        vecs[10] = mk(32'hbfc00008, 0, 1, 0, 0, 32'h0,        0, 0, 1, 32'hbfc00004, 32'h8c020010);
        vecs[11] = mk(32'hbfc00008, 0, 1, 0, 0, 32'h0,        0, 0, 1, 32'hbfc00004, 32'h8c020010);
        vecs[12] = mk(32'hbfc00008, 0, 0, 0, 0, 32'h0,        0, 1, 1, 32'hbfc00004, 32'h8c020010);
        vecs[13] = mk(32'hbfc0000c, 0, 0, 1, 0, 32'h0,        1, 0, 1, 32'hbfc00008, 32'h3c1d8000);
        vecs[14] = mk(32'hbfc00380, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'hbfc00008, 32'h3c1d8000);
        vecs[15] = mk(32'hbfc00380, 0, 0, 0, 1, 32'hdeadbeef, 0, 0, 0, 32'hbfc00008, 32'h3c1d8000);
        vecs[16] = mk(32'hbfc00380, 0, 0, 1, 0, 32'h0,        1, 0, 0, 32'hbfc00008, 32'h3c1d8000);
        vecs[17] = mk(32'hbfc00380, 0, 0, 0, 1, 32'h40806000, 0, 1, 0, 32'hbfc00008, 32'h3c1d8000);
        vecs[18] = mk(32'hbfc00384, 0, 0, 1, 0, 32'h0,        1, 0, 1, 32'hbfc00380, 32'h40806000);
        vecs[19] = mk(32'hbfc00400, 1, 0, 0, 1, 32'h11111111, 0, 0, 0, 32'hbfc00380, 32'h40806000);
        vecs[20] = mk(32'hbfc00400, 0, 0, 1, 0, 32'h0,        1, 0, 0, 32'hbfc00380, 32'h40806000);
        vecs[21] = mk(32'hbfc00400, 0, 1, 0, 1, 32'h22222222, 0, 0, 0, 32'hbfc00380, 32'h40806000);
        vecs[22] = mk(32'hbfc00500, 1, 1, 0, 0, 32'h0,        0, 0, 0, 32'hbfc00380, 32'h40806000);
        vecs[23] = mk(32'hbfc00500, 0, 0, 1, 0, 32'h0,        1, 0, 0, 32'hbfc00380, 32'h40806000);
        vecs[24] = mk(32'hbfc00500, 0, 0, 0, 1, 32'h33333333, 0, 1, 0, 32'hbfc00380, 32'h40806000);
        vecs[25] = mk(32'hbfc00504, 0, 0, 0, 0, 32'h0,        1, 0, 1, 32'hbfc00500, 32'h33333333);

        // Reset state.
        rst = 1'b1;
        drive(32'hbfc00000, 0, 0, 1, 0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req", {31'b0, inst_req}, 32'd0);
        check("rst pc_en", {31'b0, pc_en_o}, 32'd0);
        check("rst valid", {31'b0, if_valid_o}, 32'd0);
        check("rst if_pc", if_pc_o, 32'hbfc00000);
        check("rst if_inst", if_inst_o, 32'h0);
        check("rst adel", {31'b0, if_adel_o}, 32'd0);

        // Directed table: basic fetch, slow bus, stall/HOLD, flush in WAIT/with data_ok/in HOLD.
        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            drive(vecs[i].pc, vecs[i].fl, vecs[i].st, vecs[i].aok, vecs[i].dok, vecs[i].rd);
            @(negedge clk);
            check($sformatf("vec%0d req", i), {31'b0, inst_req}, {31'b0, vecs[i].e_req});
            check($sformatf("vec%0d pc_en", i), {31'b0, pc_en_o}, {31'b0, vecs[i].e_pcen});
            check($sformatf("vec%0d valid", i), {31'b0, if_valid_o}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d if_pc", i), if_pc_o, vecs[i].e_pc);
            check($sformatf("vec%0d if_inst", i), if_inst_o, vecs[i].e_inst);
            if (vecs[i].e_req) check($sformatf("vec%0d addr", i), inst_addr, vecs[i].pc);
        end

        // Misaligned PC after a flush retarget.
        @(posedge clk); #1;
        drive(32'hbfc00002, 1, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("mis flush req", {31'b0, inst_req}, 32'd0);
        check("mis flush pc_en", {31'b0, pc_en_o}, 32'd0);
`ifdef ADDR_CHECK_EN
        @(posedge clk); #1;
        drive(32'hbfc00002, 0, 0, 1, 0, 32'h0);
        @(negedge clk);
        check("adel req", {31'b0, inst_req}, 32'd0);
        check("adel pc_en", {31'b0, pc_en_o}, 32'd1);
        @(posedge clk); #1;
        drive(32'hbfc00006, 0, 1, 0, 0, 32'h0);
        @(negedge clk);
        check("adel valid", {31'b0, if_valid_o}, 32'd1);
        check("adel flag", {31'b0, if_adel_o}, 32'd1);
        check("adel inst", if_inst_o, 32'h0);
        check("adel if_pc", if_pc_o, 32'hbfc00002);
        check("adel stalled pc_en", {31'b0, pc_en_o}, 32'd0);
        @(posedge clk); #1;
        drive(32'hbfc00600, 1, 1, 0, 0, 32'h0);
        @(negedge clk);
        check("adel held", {31'b0, if_adel_o}, 32'd1);
        @(posedge clk); #1;
        drive(32'hbfc00600, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("adel cleared", {31'b0, if_adel_o}, 32'd0);
        check("adel valid cleared", {31'b0, if_valid_o}, 32'd0);
`else
        @(posedge clk); #1;
        drive(32'hbfc00002, 0, 0, 1, 0, 32'h0);
        @(negedge clk);
        check("mis req", {31'b0, inst_req}, 32'd1);
        check("mis addr", inst_addr, 32'hbfc00002);
        @(posedge clk); #1;
        drive(32'hbfc00002, 0, 0, 0, 1, 32'ha5a5a5a5);
        @(negedge clk);
        check("mis pc_en", {31'b0, pc_en_o}, 32'd1);
        @(posedge clk); #1;
        drive(32'hbfc00006, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("mis valid", {31'b0, if_valid_o}, 32'd1);
        check("mis if_pc", if_pc_o, 32'hbfc00002);
        check("mis if_inst", if_inst_o, 32'ha5a5a5a5);
        check("mis adel", {31'b0, if_adel_o}, 32'd0);
`endif

        // Randomized traffic: bench acts as PC register and bus; model tracks transactions.
        @(posedge clk); #1;
        rst = 1'b1;
        drive(32'hbfc00000, 0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        pc_reg    = 32'hbfc00000;
        exp_valid = 1'b0;
        exp_pc    = 32'hbfc00000;
        exp_inst  = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            logic       in_rst, e_req, e_pcen, from_rdy;
            fetch_pkt_t item;
            txn_t       resp;
            @(posedge clk); #1;
            in_rst       = (i >= 1000 && i < 1003);
            rst          = in_rst;
            flush_i      = !in_rst && ($urandom % 10 == 0);
            stall_i      = ($urandom % 3 == 0);
            inst_addr_ok = $urandom % 2;
            inst_data_ok = !in_rst && (outq.size() != 0) && ($urandom % 3 == 0);
            tgt          = 32'hbfc00000 | ($urandom & 32'h0000fffc);
            pc_i         = flush_i ? tgt : pc_reg;
            inst_rdata   = inst_data_ok ? mem_word(outq[0].pc) : $urandom;

            e_req    = !in_rst && !flush_i && outq.size() == 0 && rdyq.size() == 0;
            e_pcen   = 1'b0;
            from_rdy = 1'b0;
            item     = '{pc: 32'h0, inst: 32'h0, adel: 1'b0};
            if (!in_rst && !flush_i && !stall_i) begin
                if (rdyq.size() != 0) begin
                    e_pcen = 1'b1; from_rdy = 1'b1; item = rdyq[0];
                end else if (inst_data_ok && !outq[0].drop) begin
                    e_pcen = 1'b1; item = '{pc: outq[0].pc, inst: inst_rdata, adel: 1'b0};
                end
            end

            @(negedge clk);
            check($sformatf("rnd%0d req", i), {31'b0, inst_req}, {31'b0, e_req});
            check($sformatf("rnd%0d pc_en", i), {31'b0, pc_en_o}, {31'b0, e_pcen});
            check($sformatf("rnd%0d valid", i), {31'b0, if_valid_o}, {31'b0, exp_valid});
            check($sformatf("rnd%0d if_pc", i), if_pc_o, exp_pc);
            check($sformatf("rnd%0d if_inst", i), if_inst_o, exp_inst);
            check($sformatf("rnd%0d adel", i), {31'b0, if_adel_o}, 32'd0);
            if (e_req) check($sformatf("rnd%0d addr", i), inst_addr, pc_i);

            if (in_rst) begin
                outq.delete();
                rdyq.delete();
                exp_valid = 1'b0;
                exp_pc    = 32'hbfc00000;
                exp_inst  = 32'h0;
                pc_reg    = 32'hbfc00000;
            end else begin
                if (flush_i) exp_valid = 1'b0;
                else if (!stall_i) begin
                    exp_valid = e_pcen;
                    if (e_pcen) begin
                        exp_pc   = item.pc;
                        exp_inst = item.inst;
                    end
                end
                if (from_rdy) void'(rdyq.pop_front());
                if (inst_data_ok) begin
                    resp = outq.pop_front();
                    if (!resp.drop && !flush_i && stall_i)
                        rdyq.push_back('{pc: resp.pc, inst: inst_rdata, adel: 1'b0});
                end
                if (flush_i) begin
                    if (outq.size() != 0) begin
                        resp      = outq[0];
                        resp.drop = 1'b1;
                        outq[0]   = resp;
                    end
                    rdyq.delete();
                end
                if (e_req && inst_addr_ok) outq.push_back('{pc: pc_i, drop: 1'b0});
                pc_reg = flush_i ? tgt : (e_pcen ? pc_reg + 32'd4 : pc_reg);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
